wb_timer: RTL and testbench
===========================

# wb_timer

Wishbone peripheral implementing a 32-bit prescaled down-counter timer with auto-reload and a level interrupt. It is the responder end of the point-to-point `Wishbone` interface, connected through its `Peripheral` modport to a CPU or interconnect controller. It has five word registers, one fixed-latency ack per request, and `err` for undecoded offsets or foreign addresses.

## Interface
- `BASE_ADDR`, default 32'h4000_0000: register window base; `addr[31:5]` must equal `BASE_ADDR[31:5]`.
- `PRESCALE_W`, default 16: width of the prescaler register and counter (1..32).
- `clk`  input  1  system clock; all state on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `wb`  interface  `Wishbone.Peripheral`  32-bit bus: `cyc`, `stb`, `we`, `sel[3:0]`, `addr`, `data_wr` in; `ack`, `err`, `data_rd` out.
- `irq`  output  1  registered level interrupt, `STATUS.expired & CTRL.irq_en`.

## Operation
- Register map (byte offset, word aligned; `addr[1:0]` ignored):
  - 0x00 CTRL, RW: bit0 `enable`, bit1 `auto_reload`, bit2 `irq_en`. Other bits read 0.
  - 0x04 PRESCALE, RW, `[PRESCALE_W-1:0]`: a tick occurs every PRESCALE+1 enabled cycles.
  - 0x08 COUNT, RW: the current count. A write loads the count.
  - 0x0C RELOAD, RW: the value loaded into COUNT on expiry when `auto_reload` is set.
  - 0x10 STATUS: bit0 `expired`. Write 1 to clear it. Writing 0 has no effect.
- Decode:
  - A request is `cyc & stb & ~ack & ~err`.
  - Offsets 0x14..0x1C, or a mismatch in `addr[31:5]`, give `err` instead of `ack`. No state changes.
- Writes honour `sel` per byte lane. `sel=4'b0000` is still acked with no update. Reads ignore `sel`.
- `data_rd` carries the read value in the `ack` cycle. It is 0 in all other cycles, including write acks and `err`.
- Counting:
  - While `enable` is set, the prescaler counter `pcnt` increments. When `pcnt==PRESCALE`, a tick fires and `pcnt` returns to 0.
  - On a tick with `COUNT!=0`, COUNT decrements.
  - On a tick with `COUNT==0`:
    - `expired` is set.
    - If `auto_reload` is set, COUNT is loaded from RELOAD.
    - Otherwise COUNT stays 0 and `enable` clears (one-shot).
  - The first decrement after starting from COUNT=N happens after PRESCALE+1 cycles. Expiry occurs on tick N+1.
- Events in the same cycle:
  - A bus write to COUNT overrides the tick's decrement or reload and resets `pcnt` to 0.
  - A write to PRESCALE, or `enable` going 0, resets `pcnt` to 0.
  - A hardware expiry beats a STATUS write-1-to-clear in the same cycle, so `expired` stays 1.
  - A CTRL write in the same cycle as a one-shot expiry: the written value wins.

## Timing
- Reset (async on `rst_n` low, released synchronously by design convention): all registers are 0. `ack=0`, `err=0`, `data_rd=0`, `irq=0`, `pcnt=0`.
- Latency:
  - A request sampled on edge k gives `ack` or `err` high in cycle k+1 for exactly one cycle. `ack` and `err` are never both high.
  - Write side effects are visible from the edge that raises `ack`.
  - A read returns the register value sampled on edge k.
- Strobe handling:
  - A strobe held high across the ack cycle is not re-accepted. Back-to-back requests complete at most one per 2 cycles.
  - `cyc` low ignores `stb`. Dropping `cyc` before the response is legal, but the response pulse still occurs.
- `irq` is registered. It rises on the edge after `expired` and `irq_en` are both 1, and falls on the edge after either clears.
- Reset mid-transaction drops `ack` and `err` immediately. The pending request is lost, and the controller must retry after reset.

## Test plan
- Reset then read all five offsets: each gets `ack` one cycle after `stb`, and every `data_rd` is 0.
- One-shot expiry:
  - Setup: write PRESCALE=0, COUNT=3, then CTRL=0x5.
  - Required: `expired` sets exactly 4 cycles after the CTRL ack edge, CTRL reads 0x4 and `irq` rises one cycle later.
  - Then write STATUS=1: `irq` drops.
- Auto-reload with prescaler:
  - Setup: PRESCALE=2, RELOAD=1, COUNT=1, CTRL=0x3.
  - Required: `expired` is set every 6 cycles. Readback cycles through COUNT 1, 0, 1.
- Byte lanes: write RELOAD=0xAABBCCDD with `sel=4'b0101` over 0 reads back 0x00BB00DD. A write with `sel=0` is acked with no change.
- Errors:
  - Read offset 0x14 gives `err` with `data_rd=0`.
  - Write COUNT at an address with a wrong upper field gives `err`, and COUNT is unchanged.
  - `stb` held high for 5 cycles yields responses on cycles 2 and 4 only.
- Collisions and reset:
  - A STATUS clear landing on the expiry edge leaves `expired=1`.
  - A COUNT write landing on a tick loads the written value.
  - Asserting `rst_n=0` in an ack cycle drops `ack` immediately, and all registers read 0 afterward.

Source files
------------

// File: rtl/wb_timer_if.sv
// Point-to-point Wishbone bus between one controller
// and one peripheral.
interface Wishbone;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        ack;
  logic        err;

  modport Controller (
    output cyc, stb, we, sel, addr, data_wr,
    input  ack, err, data_rd
  );

  modport Peripheral (
    input  cyc, stb, we, sel, addr, data_wr,
    output ack, err, data_rd
  );
endinterface

// File: rtl/wb_timer.sv
// Wishbone prescaled 32-bit down-counter timer with
// auto-reload and a registered level interrupt.
module wb_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  Wishbone.Peripheral wb,
  output logic       irq
);

  logic [2:0]            ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           reload_q, reload_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  expired_q, expired_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  irq_q, irq_d;

  logic        req, valid, wr, tick, expire;
  logic        s_ctrl, s_pre, s_cnt, s_rel, s_stat;
  logic [2:0]  off;
  logic [31:0] mask, cur, mval;
  logic        unused_addr;

  assign unused_addr = ^wb.addr[1:0];
  assign off    = wb.addr[4:2];
  assign s_ctrl = off == 3'd0;
  assign s_pre  = off == 3'd1;
  assign s_cnt  = off == 3'd2;
  assign s_rel  = off == 3'd3;
  assign s_stat = off == 3'd4;

  assign req   = wb.cyc & wb.stb & ~ack_q & ~err_q;
  assign valid = (wb.addr[31:5] == BASE_ADDR[31:5])
               & (off <= 3'd4);
  assign wr    = req & valid & wb.we;

  assign mask = {{8{wb.sel[3]}}, {8{wb.sel[2]}},
                 {8{wb.sel[1]}}, {8{wb.sel[0]}}};

  assign tick   = ctrl_q[0] & (pcnt_q == prescale_q);
  assign expire = tick & (count_q == '0);

  always_comb begin
    cur = '0;
    unique case (1'b1)
      s_ctrl:  cur = 32'(ctrl_q);
      s_pre:   cur = 32'(prescale_q);
      s_cnt:   cur = count_q;
      s_rel:   cur = reload_q;
      s_stat:  cur = 32'(expired_q);
      default: cur = '0;
    endcase
  end

  assign mval = (cur & ~mask) | (wb.data_wr & mask);

  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    reload_d   = reload_q;
    expired_d  = expired_q;
    if (tick) begin
      if (count_q != '0)  count_d = count_q - 32'd1;
      else if (ctrl_q[1]) count_d = reload_q;
      else                ctrl_d[0] = 1'b0;
    end
    if (expire) expired_d = 1'b1;
    // bus writes override the timer's own update
    if (wr) begin
      unique case (1'b1)
        s_ctrl: ctrl_d     = mval[2:0];
        s_pre:  prescale_d = mval[PRESCALE_W-1:0];
        s_cnt:  count_d    = mval;
        s_rel:  reload_d   = mval;
        s_stat: begin
          if (wb.sel[0] & wb.data_wr[0] & ~expire)
            expired_d = 1'b0;
        end
        default: ;
      endcase
    end
    pcnt_d = '0;
    if (ctrl_q[0] & ctrl_d[0] & ~tick
        & ~(wr & (s_pre | s_cnt)))
      pcnt_d = pcnt_q + PRESCALE_W'(1);
  end

  always_comb begin
    ack_d   = req & valid;
    err_d   = req & ~valid;
    rdata_d = (req & valid & ~wb.we) ? cur : '0;
    irq_d   = expired_q & ctrl_q[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      count_q    <= '0;
      reload_q   <= '0;
      expired_q  <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      expired_q  <= expired_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign wb.ack     = ack_q;
  assign wb.err     = err_q;
  assign wb.data_rd = rdata_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer with a cycle-level
// reference model and literal spot checks.
module tb_wb_timer;

  localparam logic [31:0] B     = 32'h4000_0000;
  localparam logic [31:0] PMASK = 32'h0000_FFFF;

  logic clk;
  logic rst_n;
  logic irq;
  int   checks;
  int   failures;

  Wishbone wbi ();

  wb_timer #(.BASE_ADDR(B), .PRESCALE_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wb   (wbi),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] pre;
    logic [31:0] cnt;
    logic [31:0] rel;
    logic [31:0] div;
    logic [31:0] rd;
    logic        exp;
    logic        ack;
    logic        err;
    logic        irq;
  } m_t;

  m_t m;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Next model state from the register-map rules.
  function automatic m_t mnext(m_t c, logic cyc, logic stb,
                               logic we, logic [3:0] sel,
                               logic [31:0] a, logic [31:0] d);
    m_t n;
    logic req, good, tick, fire;
    int off;
    logic [31:0] regv, msk, mv;
    n    = c;
    off  = int'(a[4:2]);
    req  = cyc && stb && !c.ack && !c.err;
    good = (a[31:5] == B[31:5]) && (off < 5);
    case (off)
      0: regv = {29'd0, c.ctrl};
      1: regv = c.pre;
      2: regv = c.cnt;
      3: regv = c.rel;
      4: regv = {31'd0, c.exp};
      default: regv = 32'd0;
    endcase
    n.ack = req && good;
    n.err = req && !good;
    n.rd  = (req && good && !we) ? regv : 32'd0;
    n.irq = c.exp && c.ctrl[2];
    tick  = c.ctrl[0] && (c.div == c.pre);
    fire  = tick && (c.cnt == 0);
    n.div = (c.ctrl[0] && !tick) ? c.div + 1 : 32'd0;
    if (tick && !fire) n.cnt = c.cnt - 1;
    if (fire) begin
      n.exp = 1'b1;
      if (c.ctrl[1]) n.cnt = c.rel;
      else n.ctrl[0] = 1'b0;
    end
    if (req && good && we) begin
      for (int b = 0; b < 4; b++) msk[8*b +: 8] = {8{sel[b]}};
      mv = (regv & ~msk) | (d & msk);
      case (off)
        0: n.ctrl = mv[2:0];
        1: begin n.pre = mv & PMASK; n.div = 0; end
        2: begin n.cnt = mv; n.div = 0; end
        3: n.rel = mv;
        4: if (sel[0] && d[0] && !fire) n.exp = 1'b0;
        default: ;
      endcase
    end
    if (!n.ctrl[0]) n.div = 0;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= mnext(m, wbi.cyc, wbi.stb, wbi.we, wbi.sel,
                    wbi.addr, wbi.data_wr);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_ack", {31'd0, wbi.ack}, {31'd0, m.ack});
      chk("cyc_err", {31'd0, wbi.err}, {31'd0, m.err});
      chk("cyc_rd", wbi.data_rd, m.rd);
      chk("cyc_irq", {31'd0, irq}, {31'd0, m.irq});
    end
  end

  task automatic xfer(input logic we, input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] s,
                      output logic [31:0] r,
                      output logic e);
    logic got;
    got = 1'b0;
    r = 32'd0;
    e = 1'b0;
    wbi.cyc = 1'b1;
    wbi.stb = 1'b1;
    wbi.we = we;
    wbi.addr = a;
    wbi.data_wr = d;
    wbi.sel = s;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (wbi.ack || wbi.err) begin
        got = 1'b1;
        r = wbi.data_rd;
        e = wbi.err;
      end
    end
    wbi.cyc = 1'b0;
    wbi.stb = 1'b0;
    wbi.we = 1'b0;
    if (!got) chk("resp_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] off,
                    input logic [31:0] d);
    logic [31:0] r;
    logic e;
    xfer(1'b1, B + off, d, 4'hF, r, e);
    chk("wr_err", {31'd0, e}, 32'd0);
  endtask

  task automatic rd(input logic [31:0] off,
                    output logic [31:0] r);
    logic e;
    xfer(1'b0, B + off, 32'd0, 4'hF, r, e);
    chk("rd_err", {31'd0, e}, 32'd0);
  endtask

  logic [31:0] r;
  logic e;
  logic [4:0] resp;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    wbi.cyc = 1'b0;
    wbi.stb = 1'b0;
    wbi.we = 1'b0;
    wbi.sel = 4'h0;
    wbi.addr = 32'd0;
    wbi.data_wr = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      rd(32'(4 * i), r);
      chk("reset_read", r, 32'd0);
    end

    // one-shot
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd3);
    wr(32'h00, 32'h5);
    repeat (3) @(negedge clk);
    chk("oneshot_irq_lo", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("oneshot_irq_hi", {31'd0, irq}, 32'd1);
    rd(32'h00, r);
    chk("oneshot_ctrl", r, 32'h4);
    rd(32'h10, r);
    chk("oneshot_status", r, 32'h1);
    wr(32'h10, 32'h1);
    chk("oneshot_irq_clr", {31'd0, irq}, 32'd0);

    // auto-reload
    wr(32'h04, 32'd2);
    wr(32'h0C, 32'd1);
    wr(32'h08, 32'd1);
    wr(32'h00, 32'h3);
    rd(32'h08, r);
    chk("auto_cnt_a", r, 32'd1);
    rd(32'h08, r);
    chk("auto_cnt_b", r, 32'd0);
    @(negedge clk);
    rd(32'h08, r);
    chk("auto_cnt_c", r, 32'd1);
    rd(32'h10, r);
    chk("auto_status", r, 32'd1);
    wr(32'h00, 32'h0);
    wr(32'h10, 32'h1);

    // STATUS clear on the expiry edge
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd2);
    wr(32'h00, 32'h1);
    @(negedge clk);
    wr(32'h10, 32'h1);
    rd(32'h10, r);
    chk("clr_vs_expiry", r, 32'd1);
    wr(32'h10, 32'h1);

    // COUNT write on a tick
    wr(32'h04, 32'd1);
    wr(32'h08, 32'd5);
    wr(32'h00, 32'h1);
    wr(32'h08, 32'd9);
    rd(32'h08, r);
    chk("cnt_vs_tick", r, 32'd9);
    wr(32'h00, 32'h0);
    wr(32'h08, 32'd9);

    // byte lanes
    wr(32'h0C, 32'd0);
    xfer(1'b1, B + 32'h0C, 32'hAABB_CCDD, 4'b0101, r, e);
    rd(32'h0C, r);
    chk("sel_0101", r, 32'h00BB_00DD);
    xfer(1'b1, B + 32'h0C, 32'hFFFF_FFFF, 4'b0000, r, e);
    chk("sel_0_ack", {31'd0, e}, 32'd0);
    rd(32'h0C, r);
    chk("sel_0_keep", r, 32'h00BB_00DD);

    // errors
    xfer(1'b0, B + 32'h14, 32'd0, 4'hF, r, e);
    chk("err_off14", {31'd0, e}, 32'd1);
    chk("err_off14_rd", r, 32'd0);
    xfer(1'b1, 32'h5000_0008, 32'd7, 4'hF, r, e);
    chk("err_base", {31'd0, e}, 32'd1);
    rd(32'h08, r);
    chk("err_base_cnt", r, 32'd9);

    // strobe held across the ack cycle
    wbi.cyc = 1'b1;
    wbi.stb = 1'b1;
    wbi.we = 1'b0;
    wbi.addr = B + 32'h08;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      resp[i] = wbi.ack | wbi.err;
      if (i == 3) begin
        wbi.cyc = 1'b0;
        wbi.stb = 1'b0;
      end
    end
    chk("stb_held", {27'd0, resp}, 32'b00101);

    // cyc low masks stb
    wbi.stb = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("cyc_low_ack", {31'd0, wbi.ack | wbi.err}, 32'd0);
    end
    wbi.stb = 1'b0;
    @(negedge clk);

    // reset in an ack cycle
    wbi.cyc = 1'b1;
    wbi.stb = 1'b1;
    wbi.addr = B + 32'h0C;
    @(negedge clk);
    chk("pre_rst_ack", {31'd0, wbi.ack}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("rst_drop_ack", {31'd0, wbi.ack}, 32'd0);
    wbi.cyc = 1'b0;
    wbi.stb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rd(32'(4 * i), r);
      chk("post_rst_read", r, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
